rede_io_host: RTL

//  Host-side responder for proc_fx I/O strobes. Per input port, buffers host samples in a FIFO.

---
 rtl/rede_io_host_pkg.sv | 19 +
 rtl/rede_io_fifo.sv | 47 ++++
 rtl/rede_io_host.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rede_io_host_pkg.sv
// Shared helpers for the rede host I/O responder: pointer sizing and
// the lowest-set-bit encoder also used by the address decoders.
package rede_io_host_pkg;

  // One extra MSB lets full and empty be told apart when the low bits match.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned lsb_index(input logic [31:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rede_io_fifo.sv
// Synchronous FIFO with a combinational head word; DEPTH must be a power of 2.
module rede_io_fifo
  import rede_io_host_pkg::*;
#(
  parameter int W = 31,
  parameter int DEPTH = 8,
  localparam int PW = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] count
);
  localparam int AW = PW - 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic          do_push, do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rede_io_host.sv
// Host-side responder for processor I/O strobes: per-port input FIFOs served
// on req_in, and one tagged output FIFO filled from out_en captures.
module rede_io_host
  import rede_io_host_pkg::*;
#(
  parameter int NUBITS = 31,
  parameter int NUIOIN = 4,
  parameter int NUIOOU = 4,
  parameter int FDEPTH = 8,
  localparam int IPW = $clog2(NUIOIN),
  localparam int OPW = $clog2(NUIOOU)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUIOIN-1:0] req_in,
  output logic [NUBITS-1:0] io_in,
  input  logic [NUIOOU-1:0] out_en,
  input  logic [NUBITS-1:0] io_out,
  input  logic              h_wr_valid,
  input  logic [IPW-1:0]    h_wr_port,
  input  logic [NUBITS-1:0] h_wr_data,
  output logic              h_wr_ready,
  output logic              h_rd_valid,
  input  logic              h_rd_ready,
  output logic [NUBITS-1:0] h_rd_data,
  output logic [OPW-1:0]    h_rd_port,
  output logic [NUIOIN-1:0] underrun,
  output logic              overflow,
  output logic              strobe_err,
  input  logic              clr_err
);
  localparam int CW = ptr_width(FDEPTH);
  localparam int OW = NUBITS + OPW;

  logic [NUBITS-1:0] in_dout [NUIOIN];
  logic [CW-1:0]     in_count_unused [NUIOIN];
  logic [NUIOIN-1:0] in_full, in_empty, in_push, in_pop, underrun_set;
  logic [IPW-1:0]    req_idx;
  logic              req_any, wr_port_ok;

  assign req_any    = |req_in;
  assign req_idx    = IPW'(lsb_index(32'(req_in)));
  assign wr_port_ok = ({1'b0, h_wr_port} < (IPW+1)'(NUIOIN));
  assign h_wr_ready = wr_port_ok && !in_full[h_wr_port];
  assign io_in      = (req_any && !in_empty[req_idx]) ? in_dout[req_idx] : '0;

  generate
    for (genvar gi = 0; gi < NUIOIN; gi++) begin : g_in
      logic sel;
      assign sel               = req_any && (req_idx == IPW'(gi));
      assign in_push[gi]       = h_wr_valid && h_wr_ready && (h_wr_port == IPW'(gi));
      assign in_pop[gi]        = sel && !in_empty[gi];
      assign underrun_set[gi]  = sel && in_empty[gi];

      rede_io_fifo #(.W(NUBITS), .DEPTH(FDEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_push[gi]),
        .pop   (in_pop[gi]),
        .din   (h_wr_data),
        .dout  (in_dout[gi]),
        .full  (in_full[gi]),
        .empty (in_empty[gi]),
        .count (in_count_unused[gi])
      );
    end
  endgenerate

  // Output side: head register is the front slot, the FIFO holds the rest,
  // so total capacity is capped at FDEPTH words.
  logic [OPW-1:0] out_idx;
  logic [OW-1:0]  out_word, fifo_dout, head_word_reg;
  logic [CW-1:0]  fifo_count;
  logic           out_req, out_accept, rd_pop, head_load, full_total;
  logic           fifo_push, fifo_pop, fifo_empty, fifo_full_unused;
  logic           head_valid_reg;

  assign out_req    = |out_en;
  assign out_idx    = OPW'(lsb_index(32'(out_en)));
  assign out_word   = {out_idx, io_out};
  assign rd_pop     = h_rd_ready && head_valid_reg;
  assign full_total = head_valid_reg && (fifo_count == CW'(FDEPTH - 1));
  assign out_accept = out_req && (!full_total || rd_pop);
  assign head_load  = !head_valid_reg || rd_pop;
  assign fifo_pop   = head_load && !fifo_empty;
  assign fifo_push  = out_accept && !(head_load && fifo_empty);

  rede_io_fifo #(.W(OW), .DEPTH(FDEPTH)) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (out_word),
    .dout  (fifo_dout),
    .full  (fifo_full_unused),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_valid_reg <= 1'b0;
      head_word_reg  <= '0;
    end else if (head_load) begin
      if (!fifo_empty) begin
        head_valid_reg <= 1'b1;
        head_word_reg  <= fifo_dout;
      end else if (out_accept) begin
        head_valid_reg <= 1'b1;
        head_word_reg  <= out_word;
      end else begin
        head_valid_reg <= 1'b0;
        head_word_reg  <= '0;
      end
    end
  end

  assign h_rd_valid = head_valid_reg;
  assign h_rd_data  = head_word_reg[NUBITS-1:0];
  assign h_rd_port  = head_word_reg[OW-1:NUBITS];

  // A set event in the clearing cycle wins over clr_err.
  logic [NUIOIN-1:0] underrun_reg;
  logic              overflow_reg, strobe_err_reg, multi_hot;

  assign multi_hot = (|(req_in & (req_in - NUIOIN'(1)))) ||
                     (|(out_en & (out_en - NUIOOU'(1))));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun_reg   <= '0;
      overflow_reg   <= 1'b0;
      strobe_err_reg <= 1'b0;
    end else begin
      underrun_reg   <= (underrun_reg & ~{NUIOIN{clr_err}}) | underrun_set;
      overflow_reg   <= (overflow_reg & ~clr_err) | (out_req && !out_accept);
      strobe_err_reg <= (strobe_err_reg & ~clr_err) | multi_hot;
    end
  end

  assign underrun   = underrun_reg;
  assign overflow   = overflow_reg;
  assign strobe_err = strobe_err_reg;

endmodule
